ctrl_burst_data: RTL and testbench
==================================

Name: ctrl_burst_data

Overview:
- Data-phase sequencer on the far side of the CAS scheduler.
- Accepts every issued CAS (cas_rdy/cas_req) and times out the read or write latency.
- Opens the DQ/DQS data window for BL/2 clocks, then pulses rw_done back to the CAS scheduler.
- Bursts are serialized. Pending CAS commands are held in a small timestamp FIFO.

Parameters:
- DEPTH, 4, pending-CAS FIFO entries.
- TS_W, 8, timestamp/free-running counter width; the largest latency must be below 2^(TS_W-1).
- MIN_LAT, 2, floor applied to the computed latency.

Ports:
- CK_t  in  1  controller clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- cas_rdy  in  1  one-cycle pulse: CAS issued this cycle.
- cas_req  in  3  CAS type, ddr_pkg encoding: RD, RDA, WR, WRA.
- CL  in  5  CAS read latency (tCK).
- AL  in  5  additive latency.
- CWL  in  5  CAS write latency.
- BL  in  4  burst length, 8 or 4 (chop).
- rd_en  out  1  read-capture window.
- wr_en  out  1  write-drive window.
- dqs_oe  out  1  DQS output enable, covering preamble plus write beats.
- beat_cnt  out  3  beat pair index within the current burst.
- rw_done  out  1  one-cycle pulse after each burst.
- rw_req  out  3  type of the burst that just completed; valid with rw_done.
- busy  out  1  FIFO not empty or FSM not in D_IDLE.
- fifo_full  out  1  FIFO holds DEPTH entries.
- ovf_err  out  1  sticky: a CAS was dropped.
- timing_err  out  1  sticky: a burst started later than its due stamp.

Behaviour:
- Reset: all outputs 0, FSM in D_IDLE, FIFO empty, now counter 0. Reset asserted mid-burst clears outputs in the same cycle (asynchronous).
- now: TS_W-bit free-running counter; wraps from 2^TS_W-1 to 0.
- Latency L:
  - Reads (RD, RDA): L = AL+CL.
  - Writes (WR, WRA): L = AL+CWL.
  - Computed on 6 bits, then clamped to at least MIN_LAT.
- Push: on a cas_rdy edge at cycle T, push {cas_req, due = now+L (mod 2^TS_W)}.
- Push while full: CAS dropped, ovf_err set.
- Push and pop in the same cycle: allowed, including when full.
- Due test: signed TS_W-bit difference (due - now) <= 0. This makes the test wrap-safe.
- Write preamble: also due when the difference is 1.
- FSM states:
  - D_IDLE: FIFO empty, outputs idle.
  - D_WAIT_LAT: head entry present, waiting for its due time.
    - Head is a write with difference 1 -> D_PREAMBLE.
    - Head is due -> D_BURST.
  - D_PREAMBLE: one cycle, dqs_oe=1 -> D_BURST.
  - D_BURST:
    - rd_en or wr_en high for BL/2 cycles; dqs_oe high for writes.
    - beat_cnt counts 0..BL/2-1.
    - Entry is popped on the last beat.
  - D_DONE: one cycle, rw_done=1 and rw_req set to the completed type.
    - Next head due (or write with difference 1) -> D_PREAMBLE/D_BURST.
    - Else FIFO non-empty -> D_WAIT_LAT.
    - Else -> D_IDLE.
- Cycle timing: the first beat is in cycle T+L. rw_done is in cycle T+L+BL/2.
- Late start: a head whose difference is already < 0 when the FSM reaches D_WAIT_LAT or D_DONE starts immediately and sets timing_err. A write skips its preamble only if it was already late.
- BL other than 8 or 4 is treated as 8.
- Sticky errors clear only on reset.

Optional Feature:
- Macro DDR_WR_CRC_EN.
- Defined:
  - Write bursts last BL/2+1 cycles; the extra cycle carries CRC.
  - Write rw_done moves one cycle later.
  - beat_cnt reaches BL/2 on the CRC cycle.
  - Reads unaffected.
- Undefined: write bursts last BL/2 cycles; CRC logic absent.

Decomposition:
- ddr_pkg:
  - data_fsm_type {D_IDLE, D_WAIT_LAT, D_PREAMBLE, D_BURST, D_DONE}.
  - Reuse of the RD/RDA/WR/WRA encodings.
  - MIN_LAT default constant.
- Sub-module ctrl_cas_fifo: parameterized DEPTH × (3+TS_W) synchronous FIFO with full/empty and push/pop; it drops pushes when full unless a pop occurs the same cycle.

Test Plan:
- Read, CL=11, AL=0, BL=8, cas_rdy at T=10 -> rd_en cycles 21-24, beat_cnt 0..3, rw_done at 25 with rw_req=RD.
- Write, CWL=9, AL=2, BL=8, CAS at T=10 -> dqs_oe 20-24, wr_en 21-24, rw_done 25. With DDR_WR_CRC_EN: wr_en 21-25, rw_done 26.
- Write at T=10 then read at T=12, CL=11, CWL=9, AL=0, BL=4:
  - Write: dqs_oe 18-20, wr_en 19-20, rw_done 21.
  - Read: rd_en 23-24, rw_done 25.
  - timing_err stays 0.
- Five CAS pulses on consecutive cycles, DEPTH=4 -> fifth dropped, ovf_err=1, fifo_full=1. Four bursts complete; after the first, each is late by the serialization delay, so timing_err=1.
- Wrap: force now=250, read with L=11 -> due=5, rd_en starts when now=5, no timing_err.
- Reset asserted during the second read beat -> rd_en, dqs_oe, busy drop in the same cycle. After release a new CAS behaves as the first test.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR command encodings, data-phase FSM states and latency helpers
// used by the burst data sequencer and its pending-CAS FIFO.
package ddr_pkg;

    typedef enum logic [2:0] {
        CAS_NOP = 3'd0,
        CAS_RD  = 3'd1,
        CAS_RDA = 3'd2,
        CAS_WR  = 3'd3,
        CAS_WRA = 3'd4
    } cas_cmd_e;

    typedef enum logic [2:0] {
        D_IDLE,
        D_WAIT_LAT,
        D_PREAMBLE,
        D_BURST,
        D_DONE
    } data_fsm_type;

    localparam int MIN_LAT_DEF = 2;

    function automatic logic is_write(input logic [2:0] req);
        return (req == CAS_WR) || (req == CAS_WRA);
    endfunction

    // Read latency AL+CL, write latency AL+CWL, floored at min_lat.
    function automatic logic [5:0] cas_latency(input logic [2:0] req,
                                               input logic [4:0] cl,
                                               input logic [4:0] al,
                                               input logic [4:0] cwl,
                                               input int         min_lat);
        logic [5:0] sum;
        sum = {1'b0, al} + (is_write(req) ? {1'b0, cwl} : {1'b0, cl});
        if (sum < min_lat[5:0]) begin
            sum = min_lat[5:0];
        end
        return sum;
    endfunction

    // Beat pairs per burst: BL4 chop gives 2, everything else is BL8.
    function automatic logic [2:0] burst_pairs(input logic [3:0] bl);
        return (bl == 4'd4) ? 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/ctrl_cas_fifo.sv
// Pending-CAS FIFO: DEPTH entries of W bits; a push while full is dropped
// unless a pop happens in the same cycle.
module ctrl_cas_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 11
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o      = (count_q == CW'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign drop_o      = push_i && full_o && !do_pop;
    assign head_data_o = mem_q[rd_ptr_q];

    // NOTE: storage has no reset; pointers and count alone define validity,
    // so the array maps onto plain flops or RAM without a reset tree.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_burst_data.sv
// DDR data-phase sequencer: times out CAS latency, drives the DQ/DQS window,
// pulses rw_done per burst. DDR_WR_CRC_EN adds a CRC cycle to write bursts.
module ctrl_burst_data
    import ddr_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TS_W    = 8,
    parameter int MIN_LAT = MIN_LAT_DEF
) (
    input  logic       CK_t,
    input  logic       reset,
    input  logic       cas_rdy,
    input  logic [2:0] cas_req,
    input  logic [4:0] CL,
    input  logic [4:0] AL,
    input  logic [4:0] CWL,
    input  logic [3:0] BL,
    output logic       rd_en,
    output logic       wr_en,
    output logic       dqs_oe,
    output logic [2:0] beat_cnt,
    output logic       rw_done,
    output logic [2:0] rw_req,
    output logic       busy,
    output logic       fifo_full,
    output logic       ovf_err,
    output logic       timing_err
);

    localparam int EW = 3 + TS_W;

    data_fsm_type    state_q;
    logic [TS_W-1:0] now_q, now_d;
    logic [TS_W-1:0] due_d;
    logic [2:0]      cur_req_q, beat_q, last_q, rw_req_q;
    logic            rd_en_q, wr_en_q, dqs_oe_q, rw_done_q, ovf_q, terr_q;

    logic [EW-1:0]   head_data;
    logic [2:0]      head_req, head_last;
    logic [TS_W-1:0] head_due, head_diff;
    logic            head_wr, head_late, launch_pre, launch_burst;
    logic            fifo_empty, fifo_drop, pop;

    assign now_d = now_q + 1'b1;
    assign due_d = now_q + TS_W'(cas_latency(cas_req, CL, AL, CWL, MIN_LAT));
    assign pop   = (state_q == D_BURST) && (beat_q == last_q);

    ctrl_cas_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk_i       (CK_t),
        .rst_i       (reset),
        .push_i      (cas_rdy),
        .push_data_i ({cas_req, due_d}),
        .pop_i       (pop),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    // Decisions look one cycle ahead: the state entered next edge occupies
    // the cycle where now == now_d, so the head is compared against that.
    assign head_req     = head_data[EW-1 -: 3];
    assign head_due     = head_data[TS_W-1:0];
    assign head_diff    = head_due - now_d;
    assign head_wr      = is_write(head_req);
    assign head_late    = head_diff[TS_W-1];
    assign launch_pre   = !fifo_empty && head_wr && (head_diff == TS_W'(1));
    assign launch_burst = !fifo_empty && (head_late || (head_diff == '0));

    // NOTE: head_last gets its default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        head_last = burst_pairs(BL) - 3'd1;
`ifdef DDR_WR_CRC_EN
        if (head_wr) begin
            head_last = burst_pairs(BL);
        end
`endif
    end

    always_ff @(posedge CK_t or posedge reset) begin
        if (reset) begin
            state_q   <= D_IDLE;
            now_q     <= '0;
            cur_req_q <= '0;
            beat_q    <= '0;
            last_q    <= '0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            dqs_oe_q  <= 1'b0;
            rw_done_q <= 1'b0;
            rw_req_q  <= '0;
            ovf_q     <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            now_q     <= now_d;
            rw_done_q <= 1'b0;
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                D_IDLE, D_WAIT_LAT, D_DONE: begin
                    rd_en_q  <= 1'b0;
                    wr_en_q  <= 1'b0;
                    dqs_oe_q <= 1'b0;
                    beat_q   <= '0;
                    if (launch_pre) begin
                        state_q   <= D_PREAMBLE;
                        dqs_oe_q  <= 1'b1;
                        cur_req_q <= head_req;
                        last_q    <= head_last;
                    end else if (launch_burst) begin
                        state_q   <= D_BURST;
                        rd_en_q   <= !head_wr;
                        wr_en_q   <= head_wr;
                        dqs_oe_q  <= head_wr;
                        cur_req_q <= head_req;
                        last_q    <= head_last;
                        if (head_late) begin
                            terr_q <= 1'b1;
                        end
                    end else if (!fifo_empty) begin
                        state_q <= D_WAIT_LAT;
                    end else begin
                        state_q <= D_IDLE;
                    end
                end
                D_PREAMBLE: begin
                    state_q  <= D_BURST;
                    wr_en_q  <= 1'b1;
                    dqs_oe_q <= 1'b1;
                    beat_q   <= '0;
                end
                D_BURST: begin
                    if (beat_q == last_q) begin
                        state_q   <= D_DONE;
                        rd_en_q   <= 1'b0;
                        wr_en_q   <= 1'b0;
                        dqs_oe_q  <= 1'b0;
                        beat_q    <= '0;
                        rw_done_q <= 1'b1;
                        rw_req_q  <= cur_req_q;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= D_IDLE;
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign wr_en      = wr_en_q;
    assign dqs_oe     = dqs_oe_q;
    assign beat_cnt   = beat_q;
    assign rw_done    = rw_done_q;
    assign rw_req     = rw_req_q;
    assign busy       = !fifo_empty || (state_q != D_IDLE);
    assign ovf_err    = ovf_q;
    assign timing_err = terr_q;

endmodule

// File: tb/tb_ctrl_burst_data.sv
// Bench for ctrl_burst_data: schedule model built from the CAS list plus
// literal pins at hand-computed cycles. Honors DDR_WR_CRC_EN.
module tb_ctrl_burst_data;
    import ddr_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TS_W    = 8;
    localparam int MIN_LAT = 2;
    localparam int NC      = 300;

    localparam int S_RD = 0, S_WR = 1, S_DQS = 2, S_DONE = 3, S_BEAT = 4;
    localparam int S_TERR = 5, S_OVF = 6, S_FULL = 7, S_REQ = 8, S_BUSY = 9;

    logic       CK_t = 1'b0;
    logic       reset = 1'b1;
    logic       cas_rdy = 1'b0;
    logic [2:0] cas_req = '0;
    logic [4:0] CL = '0, AL = '0, CWL = '0;
    logic [3:0] BL = 4'd8;
    logic       rd_en, wr_en, dqs_oe, rw_done, busy, fifo_full, ovf_err, timing_err;
    logic [2:0] beat_cnt, rw_req;

    always #5 CK_t = ~CK_t;

    ctrl_burst_data #(.DEPTH(DEPTH), .TS_W(TS_W), .MIN_LAT(MIN_LAT)) dut (
        .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy), .cas_req(cas_req),
        .CL(CL), .AL(AL), .CWL(CWL), .BL(BL),
        .rd_en(rd_en), .wr_en(wr_en), .dqs_oe(dqs_oe), .beat_cnt(beat_cnt),
        .rw_done(rw_done), .rw_req(rw_req), .busy(busy), .fifo_full(fifo_full),
        .ovf_err(ovf_err), .timing_err(timing_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int cyc, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
        end
    endtask

    typedef struct { int t; logic [2:0] typ; } cas_t;
    typedef struct { int cyc; int sig; int val; } pin_t;
    cas_t stim[$];
    pin_t pins[$];

    bit exp_rd[NC], exp_wr[NC], exp_dqs[NC], exp_done[NC];
    bit exp_terr[NC], exp_ovf[NC], exp_full[NC], exp_busy[NC];
    int exp_beat[NC], exp_req[NC];

    task automatic add_cas(input int t, input logic [2:0] typ);
        cas_t c;
        c.t = t; c.typ = typ;
        stim.push_back(c);
    endtask

    task automatic add_pin(input int cyc, input int sig, input int val);
        pin_t p;
        p.cyc = cyc; p.sig = sig; p.val = val;
        pins.push_back(p);
    endtask

    // Bursts run in issue order; each starts at its due cycle or as soon as
    // the previous one has finished, whichever is later.
    function automatic void build_model();
        int issue[$];
        int lastb[$];
        int prev_done = -1;
        for (int c = 0; c < NC; c++) begin
            exp_rd[c] = 0; exp_wr[c] = 0; exp_dqs[c] = 0; exp_done[c] = 0;
            exp_terr[c] = 0; exp_ovf[c] = 0; exp_full[c] = 0; exp_busy[c] = 0;
            exp_beat[c] = 0; exp_req[c] = 0;
        end
        foreach (stim[i]) begin
            int t, cnt, lat, due, earliest, start, beats;
            bit wr, pop_now;
            t = stim[i].t;
            wr = (stim[i].typ == CAS_WR) || (stim[i].typ == CAS_WRA);
            cnt = 0;
            pop_now = 0;
            foreach (issue[k]) begin
                if (issue[k] < t && lastb[k] >= t) cnt++;
                if (lastb[k] == t) pop_now = 1;
            end
            if (cnt == DEPTH && !pop_now) begin
                for (int c = t + 1; c < NC; c++) exp_ovf[c] = 1;
            end else begin
                lat = int'(AL) + (wr ? int'(CWL) : int'(CL));
                if (lat < MIN_LAT) lat = MIN_LAT;
                due = t + lat;
                earliest = (prev_done + 1 > t + 2) ? prev_done + 1 : t + 2;
                start = (due > earliest) ? due : earliest;
                beats = (BL == 4'd4) ? 2 : 4;
`ifdef DDR_WR_CRC_EN
                if (wr) beats++;
`endif
                if (start > due) begin
                    for (int c = start; c < NC; c++) exp_terr[c] = 1;
                end
                if (wr && start == due && due - 1 >= earliest) exp_dqs[due - 1] = 1;
                for (int k = 0; k < beats; k++) begin
                    exp_rd[start + k]   = !wr;
                    exp_wr[start + k]   = wr;
                    exp_dqs[start + k]  = wr;
                    exp_beat[start + k] = k;
                end
                exp_done[start + beats] = 1;
                exp_req[start + beats]  = int'(stim[i].typ);
                for (int c = t + 1; c <= start + beats; c++) exp_busy[c] = 1;
                issue.push_back(t);
                lastb.push_back(start + beats - 1);
                prev_done = start + beats;
            end
        end
        for (int c = 0; c < NC; c++) begin
            int cnt = 0;
            foreach (issue[k]) if (issue[k] < c && c <= lastb[k]) cnt++;
            exp_full[c] = (cnt == DEPTH);
        end
    endfunction

    function automatic logic [7:0] sig_val(input int s);
        case (s)
            S_RD:    return 8'(rd_en);
            S_WR:    return 8'(wr_en);
            S_DQS:   return 8'(dqs_oe);
            S_DONE:  return 8'(rw_done);
            S_BEAT:  return 8'(beat_cnt);
            S_TERR:  return 8'(timing_err);
            S_OVF:   return 8'(ovf_err);
            S_FULL:  return 8'(fifo_full);
            S_REQ:   return 8'(rw_req);
            default: return 8'(busy);
        endcase
    endfunction

    logic cmp_en = 1'b0;
    int   cyc;

    always @(posedge CK_t or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge CK_t) begin
        if (cmp_en && cyc < NC) begin
            check("rd_en",      cyc, 8'(rd_en),      8'(exp_rd[cyc]));
            check("wr_en",      cyc, 8'(wr_en),      8'(exp_wr[cyc]));
            check("dqs_oe",     cyc, 8'(dqs_oe),     8'(exp_dqs[cyc]));
            check("rw_done",    cyc, 8'(rw_done),    8'(exp_done[cyc]));
            check("beat_cnt",   cyc, 8'(beat_cnt),   8'(exp_beat[cyc]));
            check("timing_err", cyc, 8'(timing_err), 8'(exp_terr[cyc]));
            check("ovf_err",    cyc, 8'(ovf_err),    8'(exp_ovf[cyc]));
            check("fifo_full",  cyc, 8'(fifo_full),  8'(exp_full[cyc]));
            check("busy",       cyc, 8'(busy),       8'(exp_busy[cyc]));
            if (exp_done[cyc]) check("rw_req", cyc, 8'(rw_req), 8'(exp_req[cyc]));
            foreach (pins[i]) begin
                if (pins[i].cyc == cyc)
                    check($sformatf("pin_sig%0d", pins[i].sig), cyc,
                          sig_val(pins[i].sig), 8'(pins[i].val));
            end
        end
    end

    task automatic run_test(input int ncyc, input int abort_at);
        cmp_en  = 1'b0;
        reset   = 1'b1;
        cas_rdy = 1'b0;
        build_model();
        @(negedge CK_t);
        @(negedge CK_t);
        check("rst_rd_en",  -1, 8'(rd_en),      8'd0);
        check("rst_busy",   -1, 8'(busy),       8'd0);
        check("rst_ovf",    -1, 8'(ovf_err),    8'd0);
        check("rst_terr",   -1, 8'(timing_err), 8'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            cas_rdy = 1'b0;
            cas_req = '0;
            foreach (stim[i]) begin
                if (stim[i].t == c) begin
                    cas_rdy = 1'b1;
                    cas_req = stim[i].typ;
                end
            end
            if (c == abort_at) begin
                #1 cmp_en = 1'b0;
                #1 reset = 1'b1;
                #1;
                check("async_rd_en",  c, 8'(rd_en),    8'd0);
                check("async_dqs_oe", c, 8'(dqs_oe),   8'd0);
                check("async_busy",   c, 8'(busy),     8'd0);
                check("async_beat",   c, 8'(beat_cnt), 8'd0);
                break;
            end
            @(negedge CK_t);
        end
        cmp_en  = 1'b0;
        cas_rdy = 1'b0;
    endtask

    task automatic setup_t1();
        stim.delete(); pins.delete();
        CL = 5'd11; AL = 5'd0; CWL = 5'd9; BL = 4'd8;
        add_cas(10, CAS_RD);
        add_pin(20, S_RD, 0); add_pin(21, S_RD, 1); add_pin(22, S_RD, 1);
        add_pin(24, S_RD, 1); add_pin(24, S_BEAT, 3); add_pin(25, S_RD, 0);
        add_pin(25, S_DONE, 1); add_pin(25, S_REQ, int'(CAS_RD));
    endtask

    initial begin
        // Single read
        setup_t1();
        run_test(40, -1);

        // Single write, AL=2 CWL=9
        stim.delete(); pins.delete();
        CL = 5'd11; AL = 5'd2; CWL = 5'd9; BL = 4'd8;
        add_cas(10, CAS_WR);
        add_pin(19, S_DQS, 0); add_pin(20, S_DQS, 1); add_pin(20, S_WR, 0);
        add_pin(21, S_WR, 1); add_pin(24, S_WR, 1);
`ifdef DDR_WR_CRC_EN
        add_pin(25, S_WR, 1); add_pin(25, S_BEAT, 4); add_pin(26, S_DONE, 1);
        add_pin(26, S_REQ, int'(CAS_WR));
`else
        add_pin(25, S_WR, 0); add_pin(25, S_DONE, 1); add_pin(25, S_REQ, int'(CAS_WR));
`endif
        run_test(40, -1);

        // Write then read, BL4 chop
        stim.delete(); pins.delete();
        CL = 5'd11; AL = 5'd0; CWL = 5'd9; BL = 4'd4;
        add_cas(10, CAS_WR); add_cas(12, CAS_RDA);
        add_pin(18, S_DQS, 1); add_pin(19, S_WR, 1); add_pin(20, S_WR, 1);
`ifndef DDR_WR_CRC_EN
        add_pin(21, S_DONE, 1);
`endif
        add_pin(22, S_RD, 0); add_pin(23, S_RD, 1); add_pin(24, S_RD, 1);
        add_pin(25, S_DONE, 1); add_pin(25, S_REQ, int'(CAS_RDA)); add_pin(26, S_TERR, 0);
        run_test(35, -1);

        // Five back-to-back reads: overflow and serialization lateness
        stim.delete(); pins.delete();
        CL = 5'd11; AL = 5'd0; CWL = 5'd9; BL = 4'd8;
        for (int i = 0; i < 5; i++) add_cas(10 + i, CAS_RD);
        add_pin(14, S_FULL, 1); add_pin(14, S_OVF, 0); add_pin(15, S_OVF, 1);
        add_pin(25, S_DONE, 1); add_pin(25, S_TERR, 0); add_pin(26, S_TERR, 1);
        add_pin(30, S_DONE, 1); add_pin(35, S_DONE, 1); add_pin(40, S_DONE, 1);
        add_pin(41, S_BUSY, 0); add_pin(45, S_DONE, 0);
        run_test(50, -1);

        // Timestamp wrap: issue at now=250, due=5; BL=5 behaves as 8
        stim.delete(); pins.delete();
        CL = 5'd11; AL = 5'd0; CWL = 5'd9; BL = 4'd5;
        add_cas(250, CAS_RD);
        add_pin(260, S_RD, 0); add_pin(261, S_RD, 1); add_pin(264, S_RD, 1);
        add_pin(264, S_BEAT, 3); add_pin(265, S_DONE, 1); add_pin(266, S_TERR, 0);
        run_test(270, -1);

        // Latency floor: AL+CL=1 clamps to 2
        stim.delete(); pins.delete();
        CL = 5'd1; AL = 5'd0; CWL = 5'd9; BL = 4'd8;
        add_cas(10, CAS_RD);
        add_pin(11, S_RD, 0); add_pin(12, S_RD, 1); add_pin(16, S_DONE, 1);
        run_test(25, -1);

        // Reset during second read beat, then a clean repeat
        setup_t1();
        run_test(40, 22);
        setup_t1();
        run_test(40, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
